// File: rtl/des_decrypt_iter_if.sv
// Handshake bundle for the iterative DES core: block/key in, cleartext out.
// DES_ENC_MODE_EN adds the i_encrypt direction select.
interface des_decrypt_iter_if;
    logic [63:0] i_ciphertext;
    logic [63:0] i_key;
    logic        i_dv;
    logic        o_ready;
    logic [63:0] o_cleartext;
    logic        o_dv;
`ifdef DES_ENC_MODE_EN
    logic        i_encrypt;

    modport master (output i_ciphertext, i_key, i_dv, i_encrypt,
                    input  o_ready, o_cleartext, o_dv);
    modport slave  (input  i_ciphertext, i_key, i_dv, i_encrypt,
                    output o_ready, o_cleartext, o_dv);
`else
    modport master (output i_ciphertext, i_key, i_dv,
                    input  o_ready, o_cleartext, o_dv);
    modport slave  (input  i_ciphertext, i_key, i_dv,
                    output o_ready, o_cleartext, o_dv);
`endif
endinterface

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys K16..K1 by right rotation.
// Optional macro DES_ENC_MODE_EN adds an encrypt mode (left rotation, K1..K16).
module des_decrypt_iter #(
    parameter bit HOLD_OUTPUT = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    des_decrypt_iter_if.slave  bus
);

    // Tables use DES bit numbering: bit 1 is the MSB of the vector.
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2,
                                  59,51,43,35,27,19,11,3, 60,52,44,36,
                                  63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6,
                                  61,53,45,37,29,21,13,5, 28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    // Each S-box packed row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    // E expansion: group g takes DES bits 4g..4g+5 (1-based, wrapping 0 -> 32).
    function automatic logic [47:0] expand(input logic [31:0] x);
        logic [47:0] y;
        for (int g = 0; g < 8; g++)
            for (int j = 0; j < 6; j++)
                y[47-(6*g+j)] = x[31-((4*g+j+31)%32)];
        return y;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

`ifdef DES_ENC_MODE_EN
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction
`endif

    typedef enum logic {IDLE, ROUND} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  rnd_reg;
    logic [31:0] l_reg, r_reg;
    logic [27:0] c_reg, d_reg;
    logic [63:0] cleartext_reg;
    logic        dv_reg;
    logic        load, last;
`ifdef DES_ENC_MODE_EN
    logic        enc_reg;
    logic        rot_two_l;
`endif

    logic        rot_two_r;
    logic [27:0] c_use, d_use, c_next, d_next;
    logic [47:0] subkey;
    logic [47:0] f_x;
    logic [31:0] s_out;
    logic [31:0] f_out;
    logic [31:0] r_new;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_dv) begin
                    load       = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (rnd_reg == 4'd15) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Decrypt: subkey from current C/D, then rotate right for the next round.
    // Encrypt: rotate left first, use the rotated C/D, and keep it.
    always_comb begin
        rot_two_r = !(rnd_reg == 4'd0 || rnd_reg == 4'd7 || rnd_reg == 4'd14);
        c_use     = c_reg;
        d_use     = d_reg;
        c_next    = rotr28(c_reg, rot_two_r);
        d_next    = rotr28(d_reg, rot_two_r);
`ifdef DES_ENC_MODE_EN
        rot_two_l = !(rnd_reg == 4'd0 || rnd_reg == 4'd1 || rnd_reg == 4'd8 || rnd_reg == 4'd15);
        if (enc_reg) begin
            c_use  = rotl28(c_reg, rot_two_l);
            d_use  = rotl28(d_reg, rot_two_l);
            c_next = c_use;
            d_next = d_use;
        end
`endif
    end

    assign subkey = perm_pc2({c_use, d_use});
    assign f_x    = expand(r_reg) ^ subkey;

    for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
        logic [5:0] six;
        logic [5:0] idx;
        assign six = f_x[47-6*gi -: 6];
        assign idx = {six[5], six[0], six[4:1]};
        assign s_out[31-4*gi -: 4] = SBOX[gi][255-4*idx -: 4];
    end

    assign f_out = perm_p(s_out);
    assign r_new = l_reg ^ f_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rnd_reg       <= '0;
            l_reg         <= '0;
            r_reg         <= '0;
            c_reg         <= '0;
            d_reg         <= '0;
            cleartext_reg <= '0;
            dv_reg        <= 1'b0;
`ifdef DES_ENC_MODE_EN
            enc_reg       <= 1'b0;
`endif
        end else begin
            dv_reg <= 1'b0;
            if (dv_reg && !HOLD_OUTPUT) cleartext_reg <= '0;
            if (load) begin
                {l_reg, r_reg} <= perm_ip(bus.i_ciphertext);
                {c_reg, d_reg} <= perm_pc1(bus.i_key);
                rnd_reg        <= '0;
`ifdef DES_ENC_MODE_EN
                enc_reg        <= bus.i_encrypt;
`endif
            end else if (state_reg == ROUND) begin
                l_reg   <= r_reg;
                r_reg   <= r_new;
                c_reg   <= c_next;
                d_reg   <= d_next;
                rnd_reg <= rnd_reg + 4'd1;
                if (last) begin
                    // Final swap: FP is applied to {R16, L16}.
                    cleartext_reg <= perm_fp({r_new, r_reg});
                    dv_reg        <= 1'b1;
                end
            end
        end
    end

    assign bus.o_ready     = (state_reg == IDLE);
    assign bus.o_dv        = dv_reg;
    assign bus.o_cleartext = cleartext_reg;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: directed vectors, busy/back-to-back, reset, hold modes and
// random blocks encrypted by a standalone DES model and decrypted by the core.
module tb_des_decrypt_iter;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    localparam logic [63:0] V1_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] V1_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] V1_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] V2_KEY = 64'h0E329232EA6D0D73;
    localparam logic [63:0] V2_CT  = 64'h0000000000000000;
    localparam logic [63:0] V2_PT  = 64'h8787878787878787;

    des_decrypt_iter_if bus ();
    des_decrypt_iter_if bus0 ();

    des_decrypt_iter #(.HOLD_OUTPUT(1'b1)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));
    des_decrypt_iter #(.HOLD_OUTPUT(1'b0)) dut_h0 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus0));

    assign bus0.i_ciphertext = bus.i_ciphertext;
    assign bus0.i_key        = bus.i_key;
    assign bus0.i_dv         = bus.i_dv;
`ifdef DES_ENC_MODE_EN
    assign bus0.i_encrypt    = bus.i_encrypt;
`endif

    always #5 i_clk = ~i_clk;

    // Reference model: full key schedule K1..K16 by left shifts, decrypt walks it backwards.
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2,
                                  59,51,43,35,27,19,11,3, 60,52,44,36,
                                  63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6,
                                  61,53,45,37,29,21,13,5, 28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0]  e;
        logic [31:0]  s;
        logic [31:0]  y;
        logic [5:0]   six;
        logic [255:0] sbv;
        int           row, col;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int g = 0; g < 8; g++) begin
            six = e[47-6*g -: 6];
            row = 2 * six[5] + six[0];
            col = int'(six[4:1]);
            sbv = SB[g] >> (4 * (63 - (row * 16 + col)));
            s[31-4*g -: 4] = sbv[3:0];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] model_des(input logic [63:0] blk, input logic [63:0] key,
                                              input logic decrypt);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] x, y;
        logic [31:0] l, r, t;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFTS[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ m_f(r, decrypt ? ks[15-n] : ks[n]);
            l = t;
        end
        x = {r, l};
        // Final permutation as the inverse of IP.
        for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_enc(input logic enc);
`ifdef DES_ENC_MODE_EN
        bus.i_encrypt = enc;
`else
        if (enc) $display("note: encrypt requested without DES_ENC_MODE_EN");
`endif
    endtask

    // One block through both instances; inputs are scrambled right after the accept edge.
    task automatic run_block(input logic [63:0] blk, input logic [63:0] key, input logic enc,
                             input string tag, input logic [63:0] exp);
        int n;
        int busy;
        @(negedge i_clk);
        bus.i_ciphertext = blk;
        bus.i_key        = key;
        set_enc(enc);
        bus.i_dv         = 1'b1;
        @(negedge i_clk);
        bus.i_dv         = 1'b0;
        bus.i_ciphertext = {$urandom, $urandom};
        bus.i_key        = {$urandom, $urandom};
        set_enc(1'b0);
        n    = 0;
        busy = 0;
        while (bus.o_dv !== 1'b1 && n < 40) begin
            if (bus.o_ready === 1'b0) busy++;
            @(negedge i_clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd16);
        chk({tag, " busy"}, 64'(busy), 64'd16);
        chk({tag, " result"}, bus.o_cleartext, exp);
        chk({tag, " ready"}, 64'(bus.o_ready), 64'd1);
        chk({tag, " h0 dv"}, 64'(bus0.o_dv), 64'd1);
        chk({tag, " h0 result"}, bus0.o_cleartext, exp);
        $display("%s: in %h key %h -> %h (cycles %0d)", tag, blk, key, bus.o_cleartext, n);
        @(negedge i_clk);
        chk({tag, " dv pulse"}, 64'(bus.o_dv), 64'd0);
        chk({tag, " held"}, bus.o_cleartext, exp);
        chk({tag, " h0 cleared"}, bus0.o_cleartext, 64'd0);
    endtask

    initial begin
        int n, first, second, bad, pulses;
        logic [63:0] r1, r2, pt, key, ct;
        logic        acc_ready;

        bus.i_ciphertext = '0;
        bus.i_key        = '0;
        bus.i_dv         = 1'b0;
        set_enc(1'b0);

        repeat (3) @(negedge i_clk);
        chk("rst ready", 64'(bus.o_ready), 64'd1);
        chk("rst dv", 64'(bus.o_dv), 64'd0);
        chk("rst cleartext", bus.o_cleartext, 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post-rst ready", 64'(bus.o_ready), 64'd1);

        run_block(V1_CT, V1_KEY, 1'b0, "vec1", V1_PT);

        bad = 0;
        repeat (100) begin
            @(negedge i_clk);
            if (bus.o_cleartext !== V1_PT || bus.o_dv !== 1'b0) bad++;
        end
        chk("hold 100 idle", 64'(bad), 64'd0);
        $display("hold: %0d idle cycles off the held value", bad);

        run_block(V2_CT, V2_KEY, 1'b0, "vec2", V2_PT);

        // Back-to-back with i_dv held; inputs switch to vector 2 in the busy window.
        @(negedge i_clk);
        bus.i_ciphertext = V1_CT;
        bus.i_key        = V1_KEY;
        bus.i_dv         = 1'b1;
        @(negedge i_clk);
        n = 0; first = -1; second = -1; r1 = '0; r2 = '0; acc_ready = 1'b1;
        while (n < 60 && second < 0) begin
            if (n == 4) begin
                bus.i_ciphertext = V2_CT;
                bus.i_key        = V2_KEY;
            end
            if (bus.o_dv === 1'b1) begin
                if (first < 0) begin first = n; r1 = bus.o_cleartext; end
                else begin second = n; r2 = bus.o_cleartext; end
            end
            if (n == 17) begin
                acc_ready = bus.o_ready;
                bus.i_dv  = 1'b0;
            end
            @(negedge i_clk);
            n++;
        end
        chk("b2b first dv", 64'(first), 64'd16);
        chk("b2b gap", 64'(second - first), 64'd17);
        chk("b2b result1", r1, V1_PT);
        chk("b2b result2", r2, V2_PT);
        chk("b2b accepted at N+17", 64'(acc_ready), 64'd0);
        $display("b2b: dv at %0d and %0d, results %h %h", first, second, r1, r2);

        // Reset in the middle of a block.
        @(negedge i_clk);
        bus.i_ciphertext = V1_CT;
        bus.i_key        = V1_KEY;
        bus.i_dv         = 1'b1;
        @(negedge i_clk);
        bus.i_dv = 1'b0;
        repeat (8) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("midrst ready", 64'(bus.o_ready), 64'd1);
        chk("midrst dv", 64'(bus.o_dv), 64'd0);
        chk("midrst cleartext", bus.o_cleartext, 64'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (bus.o_dv === 1'b1 || bus0.o_dv === 1'b1) pulses++;
        end
        chk("midrst no pulse", 64'(pulses), 64'd0);
        $display("midrst: %0d stray pulses", pulses);
        run_block(V1_CT, V1_KEY, 1'b0, "after rst", V1_PT);

        for (int i = 0; i < 12; i++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom};
            ct  = model_des(pt, key, 1'b0);
            run_block(ct, key, 1'b0, $sformatf("rand%0d", i), pt);
        end

`ifdef DES_ENC_MODE_EN
        run_block(V1_PT, V1_KEY, 1'b1, "enc vec1", V1_CT);
        run_block(V1_CT, V1_KEY, 1'b0, "dec vec1", V1_PT);
        for (int i = 0; i < 4; i++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom};
            run_block(pt, key, 1'b1, $sformatf("enc rand%0d", i), model_des(pt, key, 1'b0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
